// File: rtl/wb_mem_slave.sv
// wb_mem_slave
// Wishbone classic slave that fronts a word-organised 32-bit memory.
// Each transfer is captured in IDLE. It then spends WAIT_STATES cycles in
// WAIT and one cycle in RESP. The ack/err pulse is registered on the edge
// that leaves RESP, so it is visible in the cycle after RESP.
// A valid write is committed on the edge that enters RESP. If the cycle is
// aborted in WAIT, or reset arrives before RESP, nothing is written.
// Memory contents are not reset.
module wb_mem_slave #(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          DEPTH_LOG2  = 10,
  parameter int          WAIT_STATES = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [31:0] wbs_addr_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [3:0]  wbs_sel_i,
  output logic [31:0] wbs_dat_o,
  output logic        wbs_ack_o,
  output logic        wbs_err_o
);

  localparam int          DEPTH       = 1 << DEPTH_LOG2;
  // Size of the decoded window in bytes. It is 33 bits wide, so a window
  // that ends exactly at 2**32 still compares correctly.
  localparam logic [32:0] MEM_BYTES_C = 33'd4 << DEPTH_LOG2;
  localparam bit          HAS_WAIT_C  = (WAIT_STATES > 0);
  // Value of the wait counter on the last WAIT cycle.
  localparam logic [3:0]  WS_LAST_C   = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Merge new write data into an existing word, byte lane by byte lane.
  function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  lane_en);
    logic [31:0] merged;
    merged = old_word;
    for (int lane = 0; lane < 4; lane++) begin
      if (lane_en[lane]) begin
        merged[8*lane +: 8] = new_word[8*lane +: 8];
      end
    end
    return merged;
  endfunction

  // FSM and response registers
  state_t      state_r;
  state_t      state_nxt_s;
  logic [3:0]  cnt_r;
  logic [3:0]  cnt_nxt_s;
  logic        ack_r;
  logic        ack_nxt_s;
  logic        err_r;
  logic        err_nxt_s;
  logic [31:0] rdat_r;
  logic [31:0] rdat_nxt_s;

  // Captured request
  logic        we_r;
  logic [31:0] addr_r;
  logic [31:0] wdat_r;
  logic [3:0]  sel_r;
  logic        capture_s;

  // The transfer currently being worked on. In IDLE this is the live bus;
  // in any other state it is the captured copy.
  logic        txn_we_s;
  logic [31:0] txn_addr_s;
  logic [31:0] txn_dat_s;
  logic [3:0]  txn_sel_s;
  logic [31:0] txn_off_s;
  logic        txn_ok_s;
  logic [DEPTH_LOG2-1:0] txn_idx_s;

  logic        mem_we_s;
  logic [31:0] mem_r [DEPTH];

  // Select the live bus or the captured request, then decode its address.
  always_comb begin
    txn_we_s   = we_r;
    txn_addr_s = addr_r;
    txn_dat_s  = wdat_r;
    txn_sel_s  = sel_r;
    if (state_r == ST_IDLE) begin
      txn_we_s   = wbs_we_i;
      txn_addr_s = wbs_addr_i;
      txn_dat_s  = wbs_dat_i;
      txn_sel_s  = wbs_sel_i;
    end else begin
      txn_we_s   = we_r;
      txn_addr_s = addr_r;
      txn_dat_s  = wdat_r;
      txn_sel_s  = sel_r;
    end
    txn_off_s = txn_addr_s - BASE_ADDR;
    txn_ok_s  = (txn_addr_s[1:0] == 2'b00) &&
                (txn_addr_s >= BASE_ADDR) &&
                ({1'b0, txn_off_s} < MEM_BYTES_C);
    txn_idx_s = txn_off_s[DEPTH_LOG2+1:2];
  end

  // Next-state logic, memory write strobe and next values of the response registers.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    capture_s   = 1'b0;
    mem_we_s    = 1'b0;
    ack_nxt_s   = 1'b0;
    err_nxt_s   = 1'b0;
    rdat_nxt_s  = rdat_r;
    case (state_r)
      ST_IDLE: begin
        if (wbs_cyc_i && wbs_stb_i) begin
          capture_s = 1'b1;
          cnt_nxt_s = 4'd0;
          if (HAS_WAIT_C) begin
            state_nxt_s = ST_WAIT;
          end else begin
            // No wait states: RESP is entered now, so commit the write now.
            state_nxt_s = ST_RESP;
            mem_we_s    = txn_we_s && txn_ok_s;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (!wbs_cyc_i) begin
          // The master abandoned the cycle, so drop the transfer silently.
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = 4'd0;
        end else if (cnt_r == WS_LAST_C) begin
          state_nxt_s = ST_RESP;
          cnt_nxt_s   = 4'd0;
          mem_we_s    = txn_we_s && txn_ok_s;
        end else begin
          state_nxt_s = ST_WAIT;
          cnt_nxt_s   = cnt_r + 4'd1;
        end
      end
      ST_RESP: begin
        // The transfer is already committed; cyc_i is not consulted here.
        state_nxt_s = ST_IDLE;
        ack_nxt_s   = txn_ok_s;
        err_nxt_s   = !txn_ok_s;
        if (txn_ok_s && !txn_we_s) begin
          rdat_nxt_s = mem_r[txn_idx_s];
        end else begin
          rdat_nxt_s = rdat_r;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = 4'd0;
      end
    endcase
  end

  // State, wait counter and registered bus outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
      ack_r   <= 1'b0;
      err_r   <= 1'b0;
      rdat_r  <= 32'h0000_0000;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      ack_r   <= ack_nxt_s;
      err_r   <= err_nxt_s;
      rdat_r  <= rdat_nxt_s;
    end
  end

  // Hold the accepted request so that bus changes after acceptance are ignored.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      we_r   <= 1'b0;
      addr_r <= 32'h0000_0000;
      wdat_r <= 32'h0000_0000;
      sel_r  <= 4'h0;
    end else if (capture_s) begin
      we_r   <= wbs_we_i;
      addr_r <= wbs_addr_i;
      wdat_r <= wbs_dat_i;
      sel_r  <= wbs_sel_i;
    end
  end

  // Byte-lane memory write. The array has no reset, so it maps onto plain RAM.
  always_ff @(posedge clk_i) begin
    if (mem_we_s) begin
      mem_r[txn_idx_s] <= merge_lanes(mem_r[txn_idx_s], txn_dat_s, txn_sel_s);
    end
  end

  assign wbs_dat_o = rdat_r;
  assign wbs_ack_o = ack_r;
  assign wbs_err_o = err_r;

endmodule

// File: tb/tb_wb_mem_slave.sv
// tb_wb_mem_slave
// Three instances of wb_mem_slave with WAIT_STATES 1, 3 and 0. A word-array
// reference model predicts read data, error responses and response latency.
`timescale 1ns/1ps
module tb_wb_mem_slave;

  localparam logic [31:0]    BASE   = 32'h8000_0000;
  localparam longint         BASE_L = 64'h8000_0000;
  localparam int             DEPTH  = 1024;

  typedef struct {
    int          idx;
    int          n_ack;
    int          n_err;
    int          n_both;
    logic [31:0] pre;
    logic [31:0] resp;
    logic [31:0] post;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cyc  [3];
  logic        stb  [3];
  logic        we   [3];
  logic [31:0] addr [3];
  logic [31:0] wdat [3];
  logic [3:0]  sel  [3];
  logic [31:0] rdat [3];
  logic        ack  [3];
  logic        err  [3];

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] ref_mem [3][DEPTH];
  logic [31:0] ref_dat [3];

  always #5 clk = ~clk;

  wb_mem_slave #(.BASE_ADDR(BASE), .DEPTH_LOG2(10), .WAIT_STATES(1)) u_ws1 (
    .clk_i(clk), .rst_ni(rst_n), .wbs_cyc_i(cyc[0]), .wbs_stb_i(stb[0]),
    .wbs_we_i(we[0]), .wbs_addr_i(addr[0]), .wbs_dat_i(wdat[0]), .wbs_sel_i(sel[0]),
    .wbs_dat_o(rdat[0]), .wbs_ack_o(ack[0]), .wbs_err_o(err[0]));

  wb_mem_slave #(.BASE_ADDR(BASE), .DEPTH_LOG2(10), .WAIT_STATES(3)) u_ws3 (
    .clk_i(clk), .rst_ni(rst_n), .wbs_cyc_i(cyc[1]), .wbs_stb_i(stb[1]),
    .wbs_we_i(we[1]), .wbs_addr_i(addr[1]), .wbs_dat_i(wdat[1]), .wbs_sel_i(sel[1]),
    .wbs_dat_o(rdat[1]), .wbs_ack_o(ack[1]), .wbs_err_o(err[1]));

  wb_mem_slave #(.BASE_ADDR(BASE), .DEPTH_LOG2(10), .WAIT_STATES(0)) u_ws0 (
    .clk_i(clk), .rst_ni(rst_n), .wbs_cyc_i(cyc[2]), .wbs_stb_i(stb[2]),
    .wbs_we_i(we[2]), .wbs_addr_i(addr[2]), .wbs_dat_i(wdat[2]), .wbs_sel_i(sel[2]),
    .wbs_dat_o(rdat[2]), .wbs_ack_o(ack[2]), .wbs_err_o(err[2]));

  function automatic int ws_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 3 : 0);
  endfunction

  // Reference model: apply one transfer; report whether it should succeed.
  task automatic model_xfer(input int k, input logic w, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] s, output bit ok);
    longint unsigned ua;
    int widx;
    ua = a;
    ok = (ua % 4 == 0) && (ua >= BASE_L) && (ua < BASE_L + 4 * DEPTH);
    if (ok) begin
      widx = int'((ua - BASE_L) / 4);
      if (w) begin
        for (int b = 0; b < 4; b++)
          if (s[b]) ref_mem[k][widx][8*b +: 8] = d[8*b +: 8];
      end else begin
        ref_dat[k] = ref_mem[k][widx];
      end
    end
  endtask

  task automatic drive_req(input int k, input logic w, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] s);
    cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = w; addr[k] = a; wdat[k] = d; sel[k] = s;
  endtask

  // Let the next edge accept the request already driven, then record the response window.
  task automatic finish_req(input int k, output obs_t o);
    o.idx = -1; o.n_ack = 0; o.n_err = 0; o.n_both = 0;
    o.pre = 32'h0; o.resp = 32'h0; o.post = 32'h0;
    @(posedge clk); #1;
    stb[k] = 1'b0; we[k] = 1'($urandom); addr[k] = $urandom; wdat[k] = $urandom;
    sel[k] = 4'($urandom);
    for (int i = 0; i < ws_of(k) + 4; i++) begin
      @(negedge clk);
      if (i == 0) o.pre = rdat[k];
      if (ack[k]) o.n_ack++;
      if (err[k]) o.n_err++;
      if (ack[k] && err[k]) o.n_both++;
      if ((ack[k] || err[k]) && o.idx < 0) begin
        o.idx = i;
        o.resp = rdat[k];
      end
      o.post = rdat[k];
    end
    cyc[k] = 1'b0;
  endtask

  task automatic xfer(input int k, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] s, output obs_t o);
    @(posedge clk); #1;
    drive_req(k, w, a, d, s);
    finish_req(k, o);
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      cyc[k] = 1'b0; stb[k] = 1'b0; we[k] = 1'b0; addr[k] = 32'h0; wdat[k] = 32'h0; sel[k] = 4'h0;
    end
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      ref_dat[k] = 32'h0;
      n_checks++;
      if (ack[k] !== 1'b0 || err[k] !== 1'b0 || rdat[k] !== ref_dat[k])
        $display("FAIL reset_outputs[%0d]: got ack=%b err=%b dat=%h, want 0 0 %h",
                 k, ack[k], err[k], rdat[k], ref_dat[k]);
      else n_pass++;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_write_read();
    obs_t o; bit ok;
    model_xfer(0, 1'b1, BASE, 32'hDEAD_BEEF, 4'hF, ok);
    xfer(0, 1'b1, BASE, 32'hDEAD_BEEF, 4'hF, o);
    n_checks++;
    if (o.idx !== 1 + ws_of(0) || o.n_ack !== 1 || o.n_err !== 0)
      $display("FAIL wr_ack: got idx=%0d ack=%0d err=%0d, want idx=%0d ack=1 err=0",
               o.idx, o.n_ack, o.n_err, 1 + ws_of(0));
    else n_pass++;
    model_xfer(0, 1'b0, BASE, 32'h0, 4'h0, ok);
    xfer(0, 1'b0, BASE, 32'h0, 4'h0, o);
    n_checks++;
    if (o.idx !== 2 || o.n_ack !== 1) $display("FAIL rd_latency: got idx=%0d ack=%0d, want idx=2 ack=1", o.idx, o.n_ack);
    else n_pass++;
    n_checks++;
    if (o.resp !== 32'hDEAD_BEEF || o.resp !== ref_dat[0])
      $display("FAIL rd_data: got %h, want %h", o.resp, ref_dat[0]);
    else n_pass++;
  endtask

  task automatic test_byte_lanes();
    obs_t o; bit ok;
    model_xfer(0, 1'b1, BASE + 32'h4, 32'h1122_3344, 4'hF, ok);
    xfer(0, 1'b1, BASE + 32'h4, 32'h1122_3344, 4'hF, o);
    model_xfer(0, 1'b1, BASE + 32'h4, 32'hAABB_CCDD, 4'b0101, ok);
    xfer(0, 1'b1, BASE + 32'h4, 32'hAABB_CCDD, 4'b0101, o);
    model_xfer(0, 1'b0, BASE + 32'h4, 32'h0, 4'h0, ok);
    xfer(0, 1'b0, BASE + 32'h4, 32'h0, 4'h0, o);
    n_checks++;
    if (o.resp !== 32'h11BB_33DD || o.n_ack !== 1)
      $display("FAIL lanes_data: got %h ack=%0d, want 11bb33dd ack=1", o.resp, o.n_ack);
    else n_pass++;
    // Write with no lanes enabled: acknowledged, word unchanged.
    model_xfer(0, 1'b1, BASE + 32'h4, 32'hFFFF_FFFF, 4'h0, ok);
    xfer(0, 1'b1, BASE + 32'h4, 32'hFFFF_FFFF, 4'h0, o);
    n_checks++;
    if (o.n_ack !== (ok ? 1 : 0) || o.n_err !== (ok ? 0 : 1))
      $display("FAIL sel0_ack: got ack=%0d err=%0d, want ack=1 err=0", o.n_ack, o.n_err);
    else n_pass++;
    model_xfer(0, 1'b0, BASE + 32'h4, 32'h0, 4'hF, ok);
    xfer(0, 1'b0, BASE + 32'h4, 32'h0, 4'hF, o);
    n_checks++;
    if (o.resp !== ref_dat[0]) $display("FAIL sel0_data: got %h, want %h", o.resp, ref_dat[0]);
    else n_pass++;
  endtask

  task automatic test_errors();
    logic [31:0] bad [3];
    logic [31:0] held;
    obs_t o; bit ok;
    bad[0] = 32'h7FFF_FFFC; bad[1] = 32'h8000_0002; bad[2] = 32'h8000_1000;
    for (int i = 0; i < 3; i++) begin
      held = ref_dat[0];
      model_xfer(0, 1'b0, bad[i], 32'h0, 4'hF, ok);
      xfer(0, 1'b0, bad[i], 32'h0, 4'hF, o);
      n_checks++;
      if (o.n_err !== (ok ? 0 : 1) || o.n_ack !== (ok ? 1 : 0) || o.idx !== 1 + ws_of(0))
        $display("FAIL err_resp[%h]: got ack=%0d err=%0d idx=%0d, want ack=0 err=1 idx=%0d",
                 bad[i], o.n_ack, o.n_err, o.idx, 1 + ws_of(0));
      else n_pass++;
      n_checks++;
      if (o.post !== held) $display("FAIL err_dat_hold[%h]: got %h, want %h", bad[i], o.post, held);
      else n_pass++;
    end
    // An out-of-range write must not land anywhere (e.g. aliased onto word 0).
    model_xfer(0, 1'b1, 32'h8000_1000, 32'hCAFE_F00D, 4'hF, ok);
    xfer(0, 1'b1, 32'h8000_1000, 32'hCAFE_F00D, 4'hF, o);
    n_checks++;
    if (o.n_err !== 1 || o.n_ack !== 0) $display("FAIL err_write: got ack=%0d err=%0d, want 0 1", o.n_ack, o.n_err);
    else n_pass++;
    model_xfer(0, 1'b0, BASE, 32'h0, 4'hF, ok);
    xfer(0, 1'b0, BASE, 32'h0, 4'hF, o);
    n_checks++;
    if (o.resp !== ref_dat[0]) $display("FAIL err_no_write: got %h, want %h", o.resp, ref_dat[0]);
    else n_pass++;
  endtask

  task automatic test_abort();
    obs_t o; bit ok;
    int n_resp;
    model_xfer(1, 1'b1, BASE + 32'h8, 32'hA5A5_A5A5, 4'hF, ok);
    xfer(1, 1'b1, BASE + 32'h8, 32'hA5A5_A5A5, 4'hF, o);
    // Aborted write: it is deliberately kept out of the model.
    @(posedge clk); #1;
    drive_req(1, 1'b1, BASE + 32'h8, 32'h1234_5678, 4'hF);
    @(posedge clk); #1;
    stb[1] = 1'b0;
    @(posedge clk); #1;
    cyc[1] = 1'b0;
    n_resp = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ack[1] || err[1]) n_resp++;
    end
    n_checks++;
    if (n_resp !== 0) $display("FAIL abort_resp: got %0d response cycles, want 0", n_resp);
    else n_pass++;
    model_xfer(1, 1'b0, BASE + 32'h8, 32'h0, 4'hF, ok);
    xfer(1, 1'b0, BASE + 32'h8, 32'h0, 4'hF, o);
    n_checks++;
    if (o.resp !== ref_dat[1] || o.idx !== 1 + ws_of(1))
      $display("FAIL abort_no_write: got %h idx=%0d, want %h idx=%0d", o.resp, o.idx, ref_dat[1], 1 + ws_of(1));
    else n_pass++;
  endtask

  task automatic test_reset_mid_wait();
    obs_t o; bit ok;
    model_xfer(0, 1'b0, BASE, 32'h0, 4'hF, ok);
    xfer(0, 1'b0, BASE, 32'h0, 4'hF, o);
    // Write that reset cancels while it is still in WAIT.
    @(posedge clk); #1;
    drive_req(0, 1'b1, BASE, 32'h55AA_55AA, 4'hF);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) ref_dat[k] = 32'h0;
    n_checks++;
    if (ack[0] !== 1'b0 || err[0] !== 1'b0 || rdat[0] !== ref_dat[0])
      $display("FAIL rst_async: got ack=%b err=%b dat=%h, want 0 0 00000000", ack[0], err[0], rdat[0]);
    else n_pass++;
    drive_req(0, 1'b0, BASE, 32'h0, 4'hF);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_xfer(0, 1'b0, BASE, 32'h0, 4'hF, ok);
    finish_req(0, o);
    n_checks++;
    if (o.idx !== 1 + ws_of(0) || o.n_ack !== 1)
      $display("FAIL rst_first_req: got idx=%0d ack=%0d, want idx=%0d ack=1", o.idx, o.n_ack, 1 + ws_of(0));
    else n_pass++;
    n_checks++;
    if (o.resp !== ref_dat[0]) $display("FAIL rst_no_write: got %h, want %h", o.resp, ref_dat[0]);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    obs_t o; bit ok;
    int j, last, n_err_seen, n_stray;
    for (int w = 0; w < 8; w++) begin
      model_xfer(2, 1'b1, BASE + 32'(4 * w), $urandom, 4'hF, ok);
      xfer(2, 1'b1, BASE + 32'(4 * w), ref_mem[2][w], 4'hF, o);
    end
    @(posedge clk); #1;
    drive_req(2, 1'b0, BASE, 32'h0, 4'hF);
    j = 0; last = -1; n_err_seen = 0;
    for (int i = 0; i < 40 && j < 8; i++) begin
      @(negedge clk);
      if (err[2]) n_err_seen++;
      if (ack[2]) begin
        model_xfer(2, 1'b0, BASE + 32'(4 * j), 32'h0, 4'hF, ok);
        n_checks++;
        if (rdat[2] !== ref_dat[2]) $display("FAIL b2b_data[%0d]: got %h, want %h", j, rdat[2], ref_dat[2]);
        else n_pass++;
        n_checks++;
        if ((j == 0 && i !== 2 + ws_of(2)) || (j > 0 && i - last !== 2))
          $display("FAIL b2b_timing[%0d]: got cycle %0d (prev %0d), want spacing 2", j, i, last);
        else n_pass++;
        last = i;
        j++;
        if (j < 8) addr[2] = BASE + 32'(4 * j);
        else begin stb[2] = 1'b0; cyc[2] = 1'b0; end
      end
    end
    stb[2] = 1'b0; cyc[2] = 1'b0;
    n_stray = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (ack[2] || err[2]) n_stray++;
    end
    n_checks++;
    if (j !== 8 || n_err_seen !== 0 || n_stray !== 0)
      $display("FAIL b2b_count: got acks=%0d errs=%0d stray=%0d, want 8 0 0", j, n_err_seen, n_stray);
    else n_pass++;
  endtask

  task automatic test_random();
    obs_t o; bit ok;
    logic [31:0] a, d, held;
    logic [3:0] s;
    logic w;
    logic [31:0] bad [6];
    bad[0] = BASE - 32'h4; bad[1] = BASE + 32'h1; bad[2] = BASE + 32'h0000_0012;
    bad[3] = BASE + 32'(4 * DEPTH); bad[4] = 32'hFFFF_FFFC; bad[5] = 32'h0;
    for (int k = 0; k < 3; k++) begin
      for (int w0 = 0; w0 < 16; w0++) begin
        d = $urandom;
        model_xfer(k, 1'b1, BASE + 32'(4 * w0), d, 4'hF, ok);
        xfer(k, 1'b1, BASE + 32'(4 * w0), d, 4'hF, o);
      end
      for (int n = 0; n < 30; n++) begin
        if ($urandom_range(0, 4) == 0) a = bad[$urandom_range(0, 5)];
        else a = BASE + 32'(4 * $urandom_range(0, 15));
        w = 1'($urandom); d = $urandom; s = 4'($urandom);
        held = ref_dat[k];
        model_xfer(k, w, a, d, s, ok);
        xfer(k, w, a, d, s, o);
        n_checks++;
        if (o.idx !== 1 + ws_of(k) || o.n_ack !== (ok ? 1 : 0) || o.n_err !== (ok ? 0 : 1))
          $display("FAIL rnd_resp[%0d] a=%h we=%b: got idx=%0d ack=%0d err=%0d, want idx=%0d ack=%0d err=%0d",
                   k, a, w, o.idx, o.n_ack, o.n_err, 1 + ws_of(k), ok ? 1 : 0, ok ? 0 : 1);
        else n_pass++;
        n_checks++;
        if (o.n_both !== 0) $display("FAIL rnd_both[%0d]: got %0d overlap cycles, want 0", k, o.n_both);
        else n_pass++;
        n_checks++;
        if (o.pre !== held || o.post !== ref_dat[k])
          $display("FAIL rnd_dat[%0d] a=%h we=%b: got pre=%h post=%h, want pre=%h post=%h",
                   k, a, w, o.pre, o.post, held, ref_dat[k]);
        else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_errors();
    test_abort();
    test_reset_mid_wait();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", n_pass, n_checks);
    $fatal(1);
  end

endmodule
